nios_setup_button_pio: RTL and testbench

NIOS_SETUP_BUTTON_PIO -- requirements
Module: nios_setup_button_pio

---
 rtl/nios_setup_button_pio.sv | 114 +++++++++++
 tb/tb_nios_setup_button_pio.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nios_setup_button_pio.sv
// Avalon-MM button/switch PIO for Nios II: synchronized inputs, rising-edge capture with W1C, masked level irq.
// Optional per-bit debounce filter is built when NIOS_SETUP_BUTTON_DEBOUNCE_EN is defined.
module nios_setup_button_pio #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic             wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_port;
            sync_q    <= sync_meta;
        end
    end

`ifdef NIOS_SETUP_BUTTON_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] db_q;
    logic [CNT_W-1:0] db_cnt [WIDTH];

    // Counter measures how long the synchronized bit has disagreed with the filtered bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_q[i]   <= sync_q[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cond = db_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign cond = sync_q;
`endif

    // Capture stays off until the input pipeline has refilled after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_cnt <= 2'd0;
        end else if (prime_cnt != 2'd3) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign primed   = (prime_cnt == 2'd3);
    assign wr_en    = chipselect & ~write_n;
    assign edge_set = primed ? (cond & ~prev_q) : '0;
    assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            prev_q <= cond;
            if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
            // Set after clear so a new edge wins over a same-cycle W1C.
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = cond;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

    logic unused_wdata;
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios_setup_button_pio.sv
// Directed bench for nios_setup_button_pio (WIDTH=5); timings scale with the optional debounce filter.
module tb_nios_setup_button_pio;

`ifdef NIOS_SETUP_BUTTON_DEBOUNCE_EN
    localparam int EXTRA = 16;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  in_port;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    nios_setup_button_pio #(.WIDTH(5), .DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  inp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0,        5'b10101, 32'h15};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        5'b10101, 32'h0};
        vecs[2] = '{1'b0, 2'd0, 32'h0,        5'b01010, 32'h0A};
        vecs[3] = '{1'b0, 2'd0, 32'h0,        5'b00000, 32'h0};
        vecs[4] = '{1'b0, 2'd0, 32'h0,        5'b11111, 32'h1F};
        vecs[5] = '{1'b1, 2'd2, 32'hFFFFFFE1, 5'b11111, 32'h01};
        vecs[6] = '{1'b1, 2'd2, 32'h0000001E, 5'b11111, 32'h1E};
        vecs[7] = '{1'b1, 2'd1, 32'hFFFFFFFF, 5'b11111, 32'h0};
        vecs[8] = '{1'b1, 2'd2, 32'h00000000, 5'b11111, 32'h0};

        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 5'b11111;

        // Reset state with inputs already high, then priming
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_chk("rst_data", 2'd0, 32'h0);
        rd_chk("rst_mask", 2'd2, 32'h0);
        rd_chk("rst_edge", 2'd3, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        wr(2'd2, 32'h1F);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_chk("prime_edge", 2'd3, 32'h0);
            chk("prime_irq", {31'b0, irq}, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            in_port = vecs[i].inp;
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                repeat (4 + EXTRA) @(posedge clk);
            end
            @(negedge clk);
            rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Single rising edge on bit 0, exact latency, then W1C
        in_port = 5'b00000;
        repeat (4 + EXTRA) @(posedge clk);
        wr(2'd3, 32'h1F);
        wr(2'd2, 32'h01);
        rd_chk("edge_pre", 2'd3, 32'h0);
        @(posedge clk);
        #1 in_port = 5'b00001;
        repeat (2 + EXTRA) @(posedge clk);
        @(negedge clk);
        rd_chk("edge_early", 2'd3, 32'h0);
        chk("irq_early", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rd_chk("edge_set", 2'd3, 32'h01);
        chk("irq_set", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        rd_chk("edge_w1c", 2'd3, 32'h0);
        chk("irq_w1c", {31'b0, irq}, 32'h0);

        // Masked edge on bit 3
        wr(2'd2, 32'h0);
        @(posedge clk);
        #1 in_port = 5'b01001;
        repeat (3 + EXTRA) @(posedge clk);
        @(negedge clk);
        rd_chk("mask_edge", 2'd3, 32'h08);
        chk("mask_irq", {31'b0, irq}, 32'h0);

        // W1C colliding with a fresh bit-3 edge
        in_port = 5'b00001;
        repeat (4 + EXTRA) @(posedge clk);
        @(negedge clk);
        rd_chk("fall_noedge", 2'd3, 32'h08);
        @(posedge clk);
        #1 in_port = 5'b01001;
        repeat (1 + EXTRA) @(posedge clk);
        wr(2'd3, 32'h08);
        rd_chk("collide", 2'd3, 32'h08);
        wr(2'd3, 32'h08);
        rd_chk("clear_b3", 2'd3, 32'h0);

        // Fill edge_capture, then async reset mid-cycle
        wr(2'd2, 32'h1F);
        in_port = 5'b00000;
        repeat (4 + EXTRA) @(posedge clk);
        #1 in_port = 5'b11111;
        repeat (4 + EXTRA) @(posedge clk);
        @(negedge clk);
        rd_chk("full_edge", 2'd3, 32'h1F);
        chk("full_irq", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #2 reset = 1'b1;
        rd_chk("arst_edge", 2'd3, 32'h0);
        rd_chk("arst_mask", 2'd2, 32'h0);
        rd_chk("arst_data", 2'd0, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef NIOS_SETUP_BUTTON_DEBOUNCE_EN
        in_port = 5'b00000;
        repeat (4 + EXTRA) @(posedge clk);
        wr(2'd3, 32'h1F);
        for (int i = 0; i < 20; i++) begin
            in_port[2] = ~in_port[2];
            repeat (5) @(posedge clk);
            @(negedge clk);
            rd_chk("bounce_data", 2'd0, 32'h0);
        end
        rd_chk("bounce_edge", 2'd3, 32'h0);
        @(posedge clk);
        #1 in_port[2] = 1'b1;
        repeat (2 + 16) @(posedge clk);
        @(negedge clk);
        rd_chk("settle_data", 2'd0, 32'h04);
        @(posedge clk);
        @(negedge clk);
        rd_chk("settle_edge", 2'd3, 32'h04);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
